stk_pipe_wrbk: RTL

Writeback stage of the stack pipeline: closes the loop opened by the lookup stage. It consumes MEM-stage microcode plus banked PREV/DATA SRAM read data, then:

- returns registered head/tail pointer updates (`wrbk_uc`) to the lookup-stage register files;
- returns popped line pointers to the allocator;
- queues one response per command in a small FIFO with valid/ready handshake to the client;
- back-pressures the lookup stage through a stall flag.

---
 rtl/stk_pipe_wrbk.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/stk_pipe_wrbk.sv
// stk_pkg: shared stack-pipeline types; stk_pipe_wrbk: writeback stage.
//
// stk_pipe_wrbk consumes MEM-stage microcode plus banked PREV/DATA SRAM
// read data. It returns registered head/tail updates to the lookup RFs,
// returns popped pointers to the allocator, and queues one response per
// command in a small FIFO. It also back-pressures lookup through a stall flag.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   i_mem_*                MEM-stage slot: valid, engine, opcode, bank, popped
//                          ptr, empty flag, head/tail update microcode
//   i_prev_ptr_dout        PREV SRAM read data, one word per bank
//   i_ptr_dat_dout         DATA SRAM read data, one word per bank
//   o_wrbk_uc_*_r          registered head/tail update to the lookup RFs
//   o_free_vld_r/ptr_r     pointer returned to the allocator
//   o_rsp_*, i_rsp_rdy     response channel (valid/ready)
//   o_lk_stall_r           lookup must not issue
//   o_rsp_ovfl_r           sticky: a response was dropped

package stk_pkg;
   localparam int BANKS_N = 4;
   localparam int PTR_W   = 8;
   localparam int ENGS_N  = 4;
   localparam int DAT_W   = 128;

   typedef logic [$clog2(ENGS_N)-1:0]  engid_t;
   typedef logic [$clog2(BANKS_N)-1:0] bank_id_t;
   typedef logic [PTR_W-1:0]           ptr_t;
   typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_INV} opcode_t;

   typedef struct packed {
      engid_t           engid;
      opcode_t          opcode;
      logic             err;
      logic [DAT_W-1:0] dat;
   } rsp_t;
endpackage

module stk_pipe_wrbk
   import stk_pkg::*;
#(
   parameter int RSP_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_mem_vld_r,
   input  engid_t                          i_mem_engid_r,
   input  opcode_t                         i_mem_opcode_r,
   input  bank_id_t                        i_mem_bankid_r,
   input  ptr_t                            i_mem_ptr_r,
   input  logic                            i_mem_empty_r,
   input  logic                            i_mem_head_vld_r,
   input  ptr_t                            i_mem_head_ptr_r,
   input  logic                            i_mem_head_from_prev_r,
   input  logic                            i_mem_tail_vld_r,
   input  ptr_t                            i_mem_tail_ptr_r,
   input  logic [BANKS_N-1:0][PTR_W-1:0]   i_prev_ptr_dout,
   input  logic [BANKS_N-1:0][DAT_W-1:0]   i_ptr_dat_dout,
   output logic                            o_wrbk_uc_vld_r,
   output engid_t                          o_wrbk_uc_engid_r,
   output logic                            o_wrbk_uc_head_vld_r,
   output ptr_t                            o_wrbk_uc_head_ptr_r,
   output logic                            o_wrbk_uc_tail_vld_r,
   output ptr_t                            o_wrbk_uc_tail_ptr_r,
   output logic                            o_free_vld_r,
   output ptr_t                            o_free_ptr_r,
   output logic                            o_rsp_vld,
   input  logic                            i_rsp_rdy,
   output engid_t                          o_rsp_engid,
   output opcode_t                         o_rsp_opcode,
   output logic                            o_rsp_err,
   output logic [DAT_W-1:0]                o_rsp_dat,
   output logic                            o_lk_stall_r,
   output logic                            o_rsp_ovfl_r
);

   localparam int             AW        = $clog2(RSP_DEPTH);
   localparam logic [AW:0]    FULL_CNT  = (AW+1)'(RSP_DEPTH);
   // Two commands (LK and MEM) may already be in flight when stall is seen.
   localparam logic [AW:0]    STALL_CNT = (AW+1)'(RSP_DEPTH-2);

   logic          cmd, err, pop_ok;
   ptr_t          head_ptr_nxt;
   rsp_t          rsp_in, rsp_head;
   rsp_t          fifo [RSP_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count, count_nxt;
   logic          full, deq, wr_en;

   always_comb begin
      cmd          = i_mem_vld_r & (i_mem_opcode_r != OP_NOP);
      err          = cmd & (i_mem_opcode_r == OP_POP) & i_mem_empty_r;
      pop_ok       = cmd & (i_mem_opcode_r == OP_POP) & ~err;
      head_ptr_nxt = i_mem_head_from_prev_r ? i_prev_ptr_dout[i_mem_bankid_r]
                                            : i_mem_head_ptr_r;
      rsp_in.engid  = i_mem_engid_r;
      rsp_in.opcode = i_mem_opcode_r;
      rsp_in.err    = err;
      rsp_in.dat    = pop_ok ? i_ptr_dat_dout[i_mem_bankid_r] : '0;
   end

   // A full FIFO still accepts a write when a slot frees in the same cycle.
   always_comb begin
      full      = (count == FULL_CNT);
      deq       = (count != '0) & i_rsp_rdy;
      wr_en     = cmd & (~full | deq);
      count_nxt = count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, deq};
   end

   assign rsp_head     = fifo[rd_ptr];
   assign o_rsp_vld    = (count != '0);
   assign o_rsp_engid  = rsp_head.engid;
   assign o_rsp_opcode = rsp_head.opcode;
   assign o_rsp_err    = rsp_head.err;
   assign o_rsp_dat    = rsp_head.dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_wrbk_uc_vld_r      <= 1'b0;
         o_wrbk_uc_engid_r    <= '0;
         o_wrbk_uc_head_vld_r <= 1'b0;
         o_wrbk_uc_head_ptr_r <= '0;
         o_wrbk_uc_tail_vld_r <= 1'b0;
         o_wrbk_uc_tail_ptr_r <= '0;
         o_free_vld_r         <= 1'b0;
         o_free_ptr_r         <= '0;
         o_lk_stall_r         <= 1'b0;
         o_rsp_ovfl_r         <= 1'b0;
         rd_ptr               <= '0;
         wr_ptr               <= '0;
         count                <= '0;
         for (int i = 0; i < RSP_DEPTH; i++) fifo[i] <= '0;
      end else begin
         // Valid bits pulse once per command; fields hold between commands.
         o_wrbk_uc_vld_r      <= cmd;
         o_wrbk_uc_head_vld_r <= cmd & i_mem_head_vld_r & ~err;
         o_wrbk_uc_tail_vld_r <= cmd & i_mem_tail_vld_r & ~err;
         if (cmd) begin
            o_wrbk_uc_engid_r    <= i_mem_engid_r;
            o_wrbk_uc_head_ptr_r <= head_ptr_nxt;
            o_wrbk_uc_tail_ptr_r <= i_mem_tail_ptr_r;
         end
         o_free_vld_r <= pop_ok;
         if (pop_ok) o_free_ptr_r <= i_mem_ptr_r;

         if (wr_en) begin
            fifo[wr_ptr] <= rsp_in;
            wr_ptr       <= wr_ptr + 1'b1;
         end
         if (deq) rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
         if (cmd & full & ~deq) o_rsp_ovfl_r <= 1'b1;
         o_lk_stall_r <= (count_nxt >= STALL_CNT);
      end
   end

endmodule
